resync_fifo_1clk: RTL and testbench

//   Single-clock, first-word-fall-through FIFO that buffers parallel words between a

---
 rtl/resync_fifo_1clk.sv | 103 ++++++++++
 tb/tb_resync_fifo_1clk.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/resync_fifo_1clk.sv
// Single-clock first-word-fall-through FIFO with occupancy count and empty/almost-empty/full flags.
// Optional sticky overflow/underflow error outputs enabled by defining RESYNC_FIFO_ERR_EN.
module resync_fifo_1clk #(
    parameter int unsigned width     = 20,
    parameter int unsigned log_depth = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 val_wr,
    input  logic [width-1:0]     data_wr,
    input  logic                 val_rd,
    output logic [width-1:0]     data_rd,
    output logic                 empty_rd,
    output logic                 almost_empty_rd,
    output logic                 full_wr,
    output logic [log_depth:0]   count
`ifdef RESYNC_FIFO_ERR_EN
    ,
    output logic                 ovf_err,
    output logic                 udf_err
`endif
);

    localparam int unsigned DEPTH = 2 ** log_depth;
    localparam int unsigned CW    = log_depth + 1;
    localparam int unsigned PW    = log_depth;

    logic [width-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_acc;
    logic             rd_acc;

    // Flags decode registered occupancy only, so no path from the request inputs.
    assign empty_rd        = (count_q == CW'(0));
    assign almost_empty_rd = (count_q == CW'(1));
    assign full_wr         = (count_q == CW'(DEPTH));
    assign count           = count_q;
    assign data_rd         = mem_q[rd_ptr_q];

    always_comb begin
        wr_acc   = val_wr & ~full_wr;
        rd_acc   = val_rd & ~empty_rd;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_wr;
        end
    end

`ifdef RESYNC_FIFO_ERR_EN
    logic ovf_err_q, ovf_err_d;
    logic udf_err_q, udf_err_d;

    always_comb begin
        ovf_err_d = ovf_err_q | (val_wr & full_wr);
        udf_err_d = udf_err_q | (val_rd & empty_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_resync_fifo_1clk.sv
// Directed self-checking bench for resync_fifo_1clk (width 20, log_depth 3).
// Define RESYNC_FIFO_ERR_EN to also exercise the sticky error outputs.
module tb_resync_fifo_1clk;

    logic        clk;
    logic        rst_n;
    logic        val_wr;
    logic [19:0] data_wr;
    logic        val_rd;
    logic [19:0] data_rd;
    logic        empty_rd;
    logic        almost_empty_rd;
    logic        full_wr;
    logic [3:0]  count;
`ifdef RESYNC_FIFO_ERR_EN
    logic        ovf_err;
    logic        udf_err;
`endif

    int total = 0;
    int bad   = 0;

    resync_fifo_1clk #(.width(20), .log_depth(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .val_wr          (val_wr),
        .data_wr         (data_wr),
        .val_rd          (val_rd),
        .data_rd         (data_rd),
        .empty_rd        (empty_rd),
        .almost_empty_rd (almost_empty_rd),
        .full_wr         (full_wr),
        .count           (count)
`ifdef RESYNC_FIFO_ERR_EN
        ,
        .ovf_err         (ovf_err),
        .udf_err         (udf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int cnt);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".empty"}, 32'(empty_rd), 32'(cnt == 0));
        chk({tag, ".aempty"}, 32'(almost_empty_rd), 32'(cnt == 1));
        chk({tag, ".full"}, 32'(full_wr), 32'(cnt == 8));
    endtask

    initial begin
        rst_n   = 1'b0;
        val_wr  = 1'b0;
        val_rd  = 1'b0;
        data_wr = '0;
        step();
        step();
        rst_n = 1'b1;
        chk_flags("reset", 0);

        // Async reset mid-clock discards buffered words immediately.
        for (int i = 0; i < 3; i++) begin
            val_wr  = 1'b1;
            data_wr = 20'(32'h300 + i);
            step();
        end
        val_wr = 1'b0;
        chk_flags("pre_rst", 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk_flags("async_rst", 0);
        step();
        rst_n = 1'b1;
        step();
        chk_flags("post_rst", 0);

        // Fill to full, drop a ninth write, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            val_wr  = 1'b1;
            data_wr = 20'(i);
            step();
        end
        chk_flags("filled", 8);
        data_wr = 20'hABCDE;
        step();
        val_wr = 1'b0;
        chk_flags("drop9", 8);
        for (int i = 1; i <= 8; i++) begin
            chk("drain.data", 32'(data_rd), 32'(i));
            val_rd = 1'b1;
            step();
        end
        val_rd = 1'b0;
        chk_flags("drained", 0);

        // Single write into empty falls through after one clock.
        val_wr  = 1'b1;
        data_wr = 20'h5A5A5;
        step();
        chk("fwft.data", 32'(data_rd), 32'h5A5A5);
        chk_flags("one", 1);
        data_wr = 20'h12345;
        step();
        val_wr = 1'b0;
        chk_flags("two", 2);
        chk("two.head", 32'(data_rd), 32'h5A5A5);
        val_rd = 1'b1;
        step();
        chk("two.next", 32'(data_rd), 32'h12345);
        step();
        val_rd = 1'b0;
        chk_flags("two.drained", 0);

        // Streaming at occupancy 4 across several pointer wraps.
        for (int i = 0; i < 4; i++) begin
            val_wr  = 1'b1;
            data_wr = 20'(32'h100 + i);
            step();
        end
        for (int k = 0; k < 40; k++) begin
            chk("stream.data", 32'(data_rd), 32'h100 + 32'(k));
            val_wr  = 1'b1;
            val_rd  = 1'b1;
            data_wr = 20'(32'h104 + k);
            step();
            if (k % 10 == 9) chk_flags("stream", 4);
        end
        val_wr = 1'b0;
        for (int k = 40; k < 44; k++) begin
            chk("stream.tail", 32'(data_rd), 32'h100 + 32'(k));
            step();
        end
        val_rd = 1'b0;
        chk_flags("stream.done", 0);

        // Read+write on empty: write lands, read ignored.
        val_wr  = 1'b1;
        val_rd  = 1'b1;
        data_wr = 20'h00777;
        step();
        val_rd = 1'b0;
        chk_flags("rw_empty", 1);
        chk("rw_empty.data", 32'(data_rd), 32'h777);
        for (int i = 1; i <= 7; i++) begin
            data_wr = 20'(32'h800 + i);
            step();
        end
        chk_flags("refill", 8);
        // Read+write on full: read accepted, write dropped.
        data_wr = 20'hDEAD0;
        val_rd  = 1'b1;
        step();
        val_wr = 1'b0;
        chk_flags("rw_full", 7);
        for (int i = 1; i <= 7; i++) begin
            chk("rw_full.data", 32'(data_rd), 32'h800 + 32'(i));
            step();
        end
        val_rd = 1'b0;
        chk_flags("rw_full.drained", 0);

`ifdef RESYNC_FIFO_ERR_EN
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        chk("err.rst_ovf", 32'(ovf_err), 32'd0);
        chk("err.rst_udf", 32'(udf_err), 32'd0);
        val_rd = 1'b1;
        step();
        val_rd = 1'b0;
        chk("err.udf_set", 32'(udf_err), 32'd1);
        chk("err.ovf_clear", 32'(ovf_err), 32'd0);
        val_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_wr = 20'(i);
            step();
        end
        chk("err.ovf_notyet", 32'(ovf_err), 32'd0);
        step();
        val_wr = 1'b0;
        chk("err.ovf_set", 32'(ovf_err), 32'd1);
        step();
        step();
        chk("err.ovf_held", 32'(ovf_err), 32'd1);
        chk("err.udf_held", 32'(udf_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("err.clr_ovf", 32'(ovf_err), 32'd0);
        chk("err.clr_udf", 32'(udf_err), 32'd0);
        rst_n = 1'b1;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
